piso_shift_reg: RTL
===================

# piso_shift_reg

Parametrised parallel-in/serial-out shift register that replaces the fixed 4-bit PISO in the serialisation datapath. It accepts a WIDTH-bit word through a load/ready handshake, then emits it one bit per enabled cycle in a selectable bit order. It flags `sout_valid` for each bit and pulses `done` at end of frame. It sits between parallel producers (counters, register files) and single-wire serial links or downstream SIPO blocks.

## Interface

- `WIDTH`, default 4: parallel word width; legal range 2..32.
- `MSB_FIRST`, default 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: parallel load request; accepted only when `ready`=1.
- `a` input WIDTH: parallel data, sampled on the accepting edge.
- `shift_en` input 1: consume current serial bit on this edge (throttle).
- `ready` output 1: block idle and able to accept `load`.
- `busy` output 1: frame in progress (inverse of `ready`).
- `sout` output 1: current serial bit.
- `sout_valid` output 1: `sout` carries a frame bit this cycle.
- `done` output 1: one-cycle pulse, registered, after final bit consumed.
- `qn` output WIDTH: live shift-register contents.

## Operation

- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE: `ready`=1, `sout_valid`=0, `sout`=0. On `load`=1 the block performs these updates on the edge:
  - shift register <= `a`.
  - bit counter <= WIDTH.
  - state <= SHIFT.
- SHIFT: `sout_valid`=1 and `sout` = reg[WIDTH-1] (MSB_FIRST=1) or reg[0] (MSB_FIRST=0). On an edge with `shift_en`=1:
  - MSB_FIRST=1: reg <= {reg[WIDTH-2:0],0}; MSB_FIRST=0: reg <= {0,reg[WIDTH-1:1]}.
  - counter decrements.
  - When the counter goes 1->0: next state is IDLE (or PARITY with the macro) and `done` is set.
  - `shift_en`=0: all state holds, and `sout`/`sout_valid` are unchanged.
- `load` asserted while busy is ignored; `a` is not sampled and the frame is undisturbed.
- Counter width is $clog2(WIDTH+1); it never underflows, and it is 0 in IDLE.
- Vacated bit positions fill with 0, so `qn` is all zeros after the last data bit.

## Timing

- Reset values (asynchronous, immediate): state IDLE, reg 0, counter 0, `done` 0. This gives `qn`=0, `sout`=0, `sout_valid`=0, `busy`=0, `ready`=1.
- Load latency: the first bit is valid the cycle after the accepting edge.
- With `shift_en` held high, a frame occupies WIDTH cycles of `sout_valid`, or WIDTH+1 with parity.
- `done` is high for exactly one cycle, the cycle immediately after the edge that consumed the final bit. `ready` is 1 in that same cycle.
- Back-to-back frames: the earliest next load is accepted on the edge ending the `done` cycle. Frame period = WIDTH+1 cycles (WIDTH+2 with parity).
- Reset mid-frame: the frame is aborted and no `done` is produced. The block is in IDLE on the first edge after `rst` falls.
- `load` and `shift_en` high together in IDLE: the load is taken and `shift_en` has no effect on that edge.

## Configuration

- `PISO_PARITY_EN` defined:
  - Even parity of `a` (XOR reduction) is captured into a flop on the load edge.
  - After the last data bit, the state moves to PARITY: `sout` = parity bit and `sout_valid`=1.
  - Consuming the parity bit with `shift_en`=1 returns to IDLE and asserts `done`. `done` is produced only after the parity bit.
- `PISO_PARITY_EN` undefined: no PARITY state and no parity flop. The frame is exactly WIDTH bits.

## Test plan

- WIDTH=4, MSB_FIRST=1, `shift_en`=1, load `a`=1010 -> `sout` 1,0,1,0 on four consecutive valid cycles. `qn` goes 1010, 0100, 1000, 0000. `done` pulses in the 5th cycle.
- WIDTH=4, MSB_FIRST=0, load 1011 -> `sout` 1,1,0,1. Then load 1110 on the edge ending `done` -> `sout` 0,1,1,1 with no gap beyond one idle cycle.
- Throttle: load 1111 and toggle `shift_en` 1,0,1,0,... -> each bit held while `shift_en`=0. `done` arrives 8 cycles after load.
- Load 0110 while busy, partway through frame 1010 -> still emits 1,0,1,0; 0110 is never output and `ready` stays 0 until `done`.
- Assert `rst` after the 2nd bit of 1010 -> all outputs return to reset values immediately and no `done` occurs. A new load of 0011 afterwards emits 0,0,1,1.
- `PISO_PARITY_EN`, WIDTH=8, load 1110_0000 -> eight data bits, then parity bit 1. `done` follows the 9th valid cycle.

Source files
------------

// File: rtl/piso_shift_reg.sv
// Parametrised parallel-in/serial-out shift register with load/ready handshake.
// Define PISO_PARITY_EN to append an even-parity bit after each data frame.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic             shift_en,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [WIDTH-1:0] qn
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             sout_c, valid_c;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sout_c  = 1'b0;
        valid_c = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = a;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^a;
`endif
                end
            end
            SHIFT: begin
                valid_c = 1'b1;
                sout_c  = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
                if (shift_en) begin
                    // Vacated positions fill with zero in both directions
                    sr_d  = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                valid_c = 1'b1;
                sout_c  = par_q;
                if (shift_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign busy       = ~ready;
    assign sout       = sout_c;
    assign sout_valid = valid_c;
    assign done       = done_q;
    assign qn         = sr_q;

endmodule
